// File: rtl/cave_scroller.sv
// Side-scrolling cave playfield: keeps a circular history of cave-top samples,
// answers per-pixel wall queries for the VGA path, and detects copter/wall hits.
module cave_scroller #(
    parameter int NUM_COLS      = 64,
    parameter int COL_WIDTH     = 10,
    parameter int GAP           = 300,
    parameter int SCROLL_PERIOD = 1000000,
    parameter int COPTER_COL    = 8,
    parameter int COPTER_H      = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       gameover,
    input  logic [8:0] point,
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic [8:0] copter_y,
    output logic       in_wall,
    output logic       collide,
    output logic       scroll_tick,
    output logic       running
);
    localparam int HW       = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int CW       = (SCROLL_PERIOD > 1) ? $clog2(SCROLL_PERIOD) : 1;
    localparam int SCREEN_W = NUM_COLS * COL_WIDTH;

    localparam logic [8:0]    RESET_TOP = 9'(240 - GAP / 2);
    localparam logic [9:0]    GAP10     = 10'(GAP);
    localparam logic [9:0]    CH10      = 10'(COPTER_H);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCROLL_PERIOD - 1);
    localparam logic [HW-1:0] HEAD_LAST = HW'(NUM_COLS - 1);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [HW-1:0] head_reg;
    logic [8:0]    buf_reg [NUM_COLS];
    logic          in_wall_reg;
    logic          collide_reg;

    logic                scroll_evt;
    logic [NUM_COLS-1:0] col_we;
    logic [HW-1:0]       wall_idx;
    logic [HW-1:0]       copter_idx;
    logic                in_screen;
    logic [9:0]          wall_top, wall_bot;
    logic [9:0]          copter_top, copter_bot;
    logic                wall_hit, copter_hit;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // gameover is deliberately ignored in IDLE so a simultaneous start still runs
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (gameover || collide_reg) state_next = OVER;
            OVER:    state_next = OVER;
            default: state_next = IDLE;
        endcase
    end

    assign scroll_evt = (state_reg == RUN) && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg  <= '0;
            head_reg <= '0;
        end else if (state_reg == RUN) begin
            cnt_reg <= scroll_evt ? '0 : cnt_reg + 1'b1;
            if (scroll_evt)
                head_reg <= (head_reg == HEAD_LAST) ? '0 : head_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COLS; gi++) begin : g_we
            assign col_we[gi] = scroll_evt && (head_reg == HW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_COLS; i++) begin
            if (reset)          buf_reg[i] <= RESET_TOP;
            else if (col_we[i]) buf_reg[i] <= point;
        end
    end

    // head points at the oldest entry, so screen column c reads head+c
    always_comb begin
        int wall_sum;
        int copter_sum;
        wall_sum   = 0;
        copter_sum = 0;
        in_screen  = int'(x) < SCREEN_W;
        wall_sum   = (int'(head_reg) + int'(x) / COL_WIDTH) % NUM_COLS;
        copter_sum = (int'(head_reg) + COPTER_COL) % NUM_COLS;
        wall_idx   = HW'(wall_sum);
        copter_idx = HW'(copter_sum);
    end

    assign wall_top   = {1'b0, buf_reg[wall_idx]};
    assign wall_bot   = wall_top + GAP10;
    assign copter_top = {1'b0, buf_reg[copter_idx]};
    assign copter_bot = copter_top + GAP10;

    assign wall_hit   = in_screen && (({1'b0, y} < wall_top) || ({1'b0, y} >= wall_bot));
    assign copter_hit = ({1'b0, copter_y} < copter_top) ||
                        (({1'b0, copter_y} + CH10) > copter_bot);

    always_ff @(posedge clk) begin
        if (reset) begin
            in_wall_reg <= 1'b0;
            collide_reg <= 1'b0;
        end else begin
            in_wall_reg <= wall_hit;
            if (state_reg == RUN && copter_hit)
                collide_reg <= 1'b1;
        end
    end

    assign in_wall     = in_wall_reg;
    assign collide     = collide_reg;
    assign scroll_tick = scroll_evt;
    assign running     = (state_reg == RUN);

endmodule
